// File: rtl/rtc_access_sequencer.sv
// RTC bus command sequencer: walks the INIT / WRITE / READ transaction lists,
// driving the mux selection code and bus strobes, then waiting on listo_* handshakes.
module rtc_access_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       escribir,
  input  logic       leer,
  input  logic       listo_escribe,
  input  logic       listo_lee,
  input  logic [7:0] dato_leido,
  output logic [7:0] seleccion,
  output logic       wr_strobe,
  output logic       rd_strobe,
  output logic       ocupado,
  output logic       hecho,
  output logic       error,
  output logic [7:0] RG1,
  output logic [7:0] RG2,
  output logic [7:0] RG3
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_STB,
    S_ADDR_WAIT,
    S_DATA_STB,
    S_DATA_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    MODE_INIT,
    MODE_WRITE,
    MODE_READ
  } mode_t;

  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYC - 1);
  localparam logic [7:0]  SEL_IDLE  = 8'h00;
  localparam logic [7:0]  SEL_READ  = 8'h03;

  state_t      state, state_n;
  mode_t       mode, mode_n;
  logic [1:0]  idx, idx_n;
  logic [15:0] cnt, cnt_n;
  logic [7:0]  sel_n, rg1_n, rg2_n, rg3_n;
  logic        wr_n, rd_n, ocupado_n, hecho_n, error_n;
  logic        listo_ok, timed_out;

  function automatic logic [7:0] addr_code(input mode_t m, input logic [1:0] i);
    logic [7:0] code;
    code = 8'h00;
    case (m)
      MODE_INIT: code = (i == 2'd2) ? 8'h07 : 8'h04;
      default:   code = 8'h0A + {6'd0, i};  // WRITE and READ share 0x0A..0x0C
    endcase
    return code;
  endfunction

  function automatic logic [7:0] data_code(input mode_t m, input logic [1:0] i);
    logic [7:0] code;
    code = SEL_READ;
    case (m)
      MODE_INIT: begin
        case (i)
          2'd0:    code = 8'h05;
          2'd1:    code = 8'h06;
          default: code = 8'h08;
        endcase
      end
      MODE_WRITE: begin
        case (i)
          2'd0:    code = 8'h19;
          2'd1:    code = 8'h1D;
          default: code = 8'h1E;
        endcase
      end
      default: code = SEL_READ;
    endcase
    return code;
  endfunction

  // Next-state logic; outputs are computed from the next state so that the
  // registered outputs line up with the state they belong to.
  always_comb begin
    state_n   = state;
    mode_n    = mode;
    idx_n     = idx;
    cnt_n     = cnt;
    error_n   = error;
    rg1_n     = RG1;
    rg2_n     = RG2;
    rg3_n     = RG3;
    listo_ok  = 1'b0;
    timed_out = (cnt == LAST_WAIT);

    case (state)
      S_IDLE: begin
        if (iniciar || escribir || leer) begin
          if (iniciar)       mode_n = MODE_INIT;
          else if (escribir) mode_n = MODE_WRITE;
          else               mode_n = MODE_READ;
          idx_n   = 2'd0;
          error_n = 1'b0;
          state_n = S_ADDR_STB;
        end
      end
      S_ADDR_STB: begin
        cnt_n   = '0;
        state_n = S_ADDR_WAIT;
      end
      S_ADDR_WAIT: begin
        listo_ok = listo_escribe;
        if (listo_ok) begin
          state_n = S_DATA_STB;
        end else if (timed_out) begin
          error_n = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_DATA_STB: begin
        cnt_n   = '0;
        state_n = S_DATA_WAIT;
      end
      S_DATA_WAIT: begin
        listo_ok = (mode == MODE_READ) ? listo_lee : listo_escribe;
        if (listo_ok) begin
          if (mode == MODE_READ) begin
            case (idx)
              2'd0:    rg1_n = dato_leido;
              2'd1:    rg2_n = dato_leido;
              default: rg3_n = dato_leido;
            endcase
          end
          state_n = S_NEXT;
        end else if (timed_out) begin
          error_n = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_NEXT: begin
        if (idx == 2'd2) begin
          state_n = S_DONE;
        end else begin
          idx_n   = idx + 2'd1;
          state_n = S_ADDR_STB;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Registered-output values; WAIT/NEXT/DONE hold the last selection code.
  always_comb begin
    sel_n     = seleccion;
    wr_n      = 1'b0;
    rd_n      = 1'b0;
    ocupado_n = (state_n != S_IDLE);
    hecho_n   = (state_n == S_DONE);

    case (state_n)
      S_IDLE: sel_n = SEL_IDLE;
      S_ADDR_STB: begin
        sel_n = addr_code(mode_n, idx_n);
        wr_n  = 1'b1;
      end
      S_DATA_STB: begin
        if (mode_n == MODE_READ) begin
          sel_n = SEL_READ;
          rd_n  = 1'b1;
        end else begin
          sel_n = data_code(mode_n, idx_n);
          wr_n  = 1'b1;
        end
      end
      default: sel_n = seleccion;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      mode      <= MODE_INIT;
      idx       <= '0;
      cnt       <= '0;
      seleccion <= SEL_IDLE;
      wr_strobe <= 1'b0;
      rd_strobe <= 1'b0;
      ocupado   <= 1'b0;
      hecho     <= 1'b0;
      error     <= 1'b0;
      RG1       <= '0;
      RG2       <= '0;
      RG3       <= '0;
    end else begin
      state     <= state_n;
      mode      <= mode_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      seleccion <= sel_n;
      wr_strobe <= wr_n;
      rd_strobe <= rd_n;
      ocupado   <= ocupado_n;
      hecho     <= hecho_n;
      error     <= error_n;
      RG1       <= rg1_n;
      RG2       <= rg2_n;
      RG3       <= rg3_n;
    end
  end

endmodule

// File: tb/tb_rtc_access_sequencer.sv
// Bench for rtc_access_sequencer: randomized bus responder plus a transaction-list
// reference model of expected strobe codes, timing and captured read registers.
module tb_rtc_access_sequencer;

  localparam int unsigned TO = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0, escribir = 1'b0, leer = 1'b0;
  logic       listo_escribe = 1'b0, listo_lee = 1'b0;
  logic [7:0] dato_leido = 8'h00;
  logic [7:0] seleccion, RG1, RG2, RG3;
  logic       wr_strobe, rd_strobe, ocupado, hecho, error;

  int vectors = 0;
  int miscompares = 0;

  rtc_access_sequencer #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .iniciar(iniciar), .escribir(escribir), .leer(leer),
    .listo_escribe(listo_escribe), .listo_lee(listo_lee), .dato_leido(dato_leido),
    .seleccion(seleccion), .wr_strobe(wr_strobe), .rd_strobe(rd_strobe),
    .ocupado(ocupado), .hecho(hecho), .error(error), .RG1(RG1), .RG2(RG2), .RG3(RG3)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed strobe log and hecho times, sampled on the falling edge.
  typedef struct {
    logic        wr;
    logic        rd;
    logic [7:0]  sel;
    int unsigned cyc_at;
  } ev_t;
  ev_t         strobes[$];
  int unsigned hecho_at[$];
  ev_t         mon_ev;
  bit          holding = 0;
  bit          held_rd = 0;
  logic [7:0]  held_sel = 8'h00;
  int          sel_glitches = 0;

  always @(negedge clk) begin
    if (ocupado !== 1'b1) holding = 0;
    if (holding && seleccion !== held_sel) sel_glitches++;
    if (wr_strobe === 1'b1 || rd_strobe === 1'b1) begin
      mon_ev.wr = wr_strobe; mon_ev.rd = rd_strobe;
      mon_ev.sel = seleccion; mon_ev.cyc_at = cyc;
      strobes.push_back(mon_ev);
      holding = 1; held_sel = seleccion; held_rd = (rd_strobe === 1'b1);
    end else if (holding && (held_rd ? listo_lee : listo_escribe) === 1'b1) begin
      holding = 0;
    end
    if (hecho === 1'b1) hecho_at.push_back(cyc);
  end

  // Bus responder: 0 silent, 1 answer each strobe after a delay, 2 listo_escribe held high.
  int          bus_mode = 0;
  int unsigned bus_delay = 1;
  bit          bus_rand = 0;
  bit          bus_noise = 0;
  int          bus_budget = -1;
  int unsigned bus_cnt = 0;
  bit          bus_rd = 0;
  bit          noise_pending = 0;
  logic [7:0]  rd_data[$];

  always @(posedge clk) begin
    #1;
    listo_escribe = (bus_mode == 2);
    listo_lee = 1'b0;
    if (bus_mode != 1) begin
      bus_cnt = 0;
      noise_pending = 0;
    end else begin
      if (bus_cnt != 0) begin
        bus_cnt = bus_cnt - 1;
        if (bus_cnt == 0) begin
          if (bus_rd) begin
            listo_lee = 1'b1;
            dato_leido = (rd_data.size() != 0) ? rd_data.pop_front() : 8'h00;
          end else begin
            listo_escribe = 1'b1;
          end
        end else if (noise_pending) begin
          if (bus_rd) listo_escribe = 1'b1;
          else        listo_lee = 1'b1;
          dato_leido = 8'hEE;
        end
      end
      noise_pending = 0;
      if ((wr_strobe === 1'b1 || rd_strobe === 1'b1) && bus_budget != 0) begin
        bus_rd = (rd_strobe === 1'b1);
        bus_cnt = bus_rand ? $urandom_range(6, 1) : bus_delay;
        noise_pending = bus_noise;
        if (bus_budget > 0) bus_budget--;
      end
    end
  end

  // Reference model: the three fixed transaction lists.
  logic       exp_rd[$];
  logic [7:0] exp_sel[$];
  logic [7:0] exp_rg[3] = '{8'h00, 8'h00, 8'h00};

  function automatic void model_seq(input int m);
    logic [7:0] a[3];
    logic [7:0] d[3];
    case (m)
      0:       begin a = '{8'h04, 8'h04, 8'h07}; d = '{8'h05, 8'h06, 8'h08}; end
      1:       begin a = '{8'h0A, 8'h0B, 8'h0C}; d = '{8'h19, 8'h1D, 8'h1E}; end
      default: begin a = '{8'h0A, 8'h0B, 8'h0C}; d = '{8'h03, 8'h03, 8'h03}; end
    endcase
    for (int i = 0; i < 3; i++) begin
      exp_rd.push_back(1'b0); exp_sel.push_back(a[i]);
      exp_rd.push_back(m == 2); exp_sel.push_back(d[i]);
    end
  endfunction

  function automatic void clear_log();
    strobes.delete(); hecho_at.delete(); exp_rd.delete(); exp_sel.delete();
    sel_glitches = 0;
  endfunction

  function automatic int count_rd();
    int n = 0;
    foreach (strobes[i]) if (strobes[i].rd === 1'b1) n++;
    return n;
  endfunction

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (ocupado === 1'b0) begin ok = 1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_hecho(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (hecho_at.size() >= n) begin ok = 1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({seleccion, wr_strobe, rd_strobe, ocupado, hecho, error} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got sel=%h wr=%b rd=%b ocup=%b hecho=%b err=%b, want all 0",
               seleccion, wr_strobe, rd_strobe, ocupado, hecho, error);
    end
    vectors++;
    if ({RG1, RG2, RG3} !== 24'h000000) begin
      miscompares++;
      $display("FAIL reset_rg: got %h %h %h, want 00 00 00", RG1, RG2, RG3);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (ocupado !== 1'b0 || wr_strobe !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got ocup=%b wr=%b, want 0 0", ocupado, wr_strobe);
    end
  endtask

  task automatic test_init_immediate();
    bit ok; int unsigned t0;
    clear_log(); bus_mode = 2;
    iniciar = 1'b1; @(posedge clk); #1; t0 = cyc; iniciar = 1'b0;
    wait_idle(ok); bus_mode = 0;
    model_seq(0);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL init_done: got busy after 400 cycles, want idle"); end
    vectors++;
    if (strobes.size() != 6) begin
      miscompares++; $display("FAIL init_count: got %0d strobes, want 6", strobes.size());
    end
    for (int i = 0; i < 6 && i < strobes.size(); i++) begin
      vectors++;
      if (strobes[i].wr !== 1'b1 || strobes[i].rd !== 1'b0 || strobes[i].sel !== exp_sel[i] ||
          strobes[i].cyc_at != t0 + 5 * (i / 2) + 2 * (i % 2)) begin
        miscompares++;
        $display("FAIL init_strobe%0d: got wr=%b rd=%b sel=%h at=%0d, want wr=1 rd=0 sel=%h at=%0d",
                 i, strobes[i].wr, strobes[i].rd, strobes[i].sel, strobes[i].cyc_at - t0,
                 exp_sel[i], 5 * (i / 2) + 2 * (i % 2));
      end
    end
    vectors++;
    if (hecho_at.size() != 1 || hecho_at[0] != t0 + 15) begin
      miscompares++;
      $display("FAIL init_hecho: got %0d pulses first at +%0d, want 1 pulse at +15 (sampled on edge T+16)",
               hecho_at.size(), (hecho_at.size() != 0) ? hecho_at[0] - t0 : 0);
    end
    vectors++;
    if (sel_glitches != 0) begin
      miscompares++; $display("FAIL init_sel_stable: got %0d changes, want 0", sel_glitches);
    end
  endtask

  task automatic run_read(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input bit rnd, input bit noise);
    bit ok;
    clear_log();
    rd_data = '{d0, d1, d2}; bus_delay = 3; bus_rand = rnd; bus_noise = noise; bus_mode = 1;
    leer = 1'b1; @(posedge clk); #1; leer = 1'b0;
    wait_idle(ok); bus_mode = 0; bus_rand = 0; bus_noise = 0;
    model_seq(2); exp_rg = '{d0, d1, d2};
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL %s_done: got busy after 400 cycles, want idle", tag); end
    vectors++;
    if (strobes.size() != 6) begin
      miscompares++; $display("FAIL %s_count: got %0d strobes, want 6", tag, strobes.size());
    end
    for (int i = 0; i < 6 && i < strobes.size(); i++) begin
      vectors++;
      if (strobes[i].rd !== exp_rd[i] || strobes[i].wr !== !exp_rd[i] || strobes[i].sel !== exp_sel[i]) begin
        miscompares++;
        $display("FAIL %s_strobe%0d: got wr=%b rd=%b sel=%h, want wr=%b rd=%b sel=%h", tag, i,
                 strobes[i].wr, strobes[i].rd, strobes[i].sel, !exp_rd[i], exp_rd[i], exp_sel[i]);
      end
    end
    vectors++;
    if ({RG1, RG2, RG3} !== {exp_rg[0], exp_rg[1], exp_rg[2]}) begin
      miscompares++;
      $display("FAIL %s_rg: got %h %h %h, want %h %h %h", tag, RG1, RG2, RG3, exp_rg[0], exp_rg[1], exp_rg[2]);
    end
    vectors++;
    if (hecho_at.size() != 1 || error !== 1'b0 || sel_glitches != 0) begin
      miscompares++;
      $display("FAIL %s_status: got hecho=%0d err=%b glitches=%0d, want 1 0 0", tag,
               hecho_at.size(), error, sel_glitches);
    end
  endtask

  task automatic test_read_basic();
    run_read("read_basic", 8'h12, 8'h34, 8'h56, 1'b0, 1'b0);
  endtask

  task automatic test_read_random();
    for (int r = 0; r < 3; r++)
      run_read("read_rand", 8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b0);
  endtask

  task automatic test_wrong_kind();
    run_read("wrong_kind", 8'($urandom_range(8'hED)), 8'h5A, 8'($urandom_range(8'hED)), 1'b0, 1'b1);
    // with listo after 3 cycles: addr->data strobe gap 4, data->next addr gap 5
    for (int i = 1; i < 6 && i < strobes.size(); i++) begin
      vectors++;
      if (strobes[i].cyc_at - strobes[i - 1].cyc_at != ((i % 2 == 1) ? 4 : 5)) begin
        miscompares++;
        $display("FAIL wrong_kind_gap%0d: got %0d cycles, want %0d", i,
                 strobes[i].cyc_at - strobes[i - 1].cyc_at, (i % 2 == 1) ? 4 : 5);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok; logic [7:0] d[6];
    clear_log();
    foreach (d[i]) d[i] = 8'($urandom);
    rd_data = '{d[0], d[1], d[2], d[3], d[4], d[5]}; bus_delay = 1; bus_mode = 1;
    leer = 1'b1;
    wait_hecho(1, ok);
    @(posedge clk); #1; leer = 1'b0;
    wait_idle(ok); bus_mode = 0;
    exp_rg = '{d[3], d[4], d[5]};
    vectors++;
    if (hecho_at.size() != 2 || strobes.size() != 12) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d hecho %0d strobes, want 2 12", hecho_at.size(), strobes.size());
    end else begin
      vectors++;
      if (strobes[6].cyc_at != hecho_at[0] + 2 || strobes[6].sel !== 8'h0A) begin
        miscompares++;
        $display("FAIL b2b_retrigger: got strobe sel=%h at hecho+%0d, want sel=0a at hecho+2",
                 strobes[6].sel, strobes[6].cyc_at - hecho_at[0]);
      end
    end
    vectors++;
    if ({RG1, RG2, RG3} !== {exp_rg[0], exp_rg[1], exp_rg[2]}) begin
      miscompares++;
      $display("FAIL b2b_rg: got %h %h %h, want %h %h %h", RG1, RG2, RG3, exp_rg[0], exp_rg[1], exp_rg[2]);
    end
  endtask

  task automatic test_priority();
    bit ok;
    clear_log(); bus_mode = 2;
    iniciar = 1'b1; escribir = 1'b1; leer = 1'b1;
    @(posedge clk); #1;
    iniciar = 1'b0; escribir = 1'b0; leer = 1'b0;
    repeat (3) @(posedge clk);
    #1; escribir = 1'b1;
    wait_hecho(1, ok);
    @(posedge clk); #1; escribir = 1'b0;
    wait_idle(ok); bus_mode = 0;
    model_seq(0); model_seq(1);
    vectors++;
    if (strobes.size() != 12 || hecho_at.size() != 2) begin
      miscompares++;
      $display("FAIL prio_count: got %0d strobes %0d hecho, want 12 2", strobes.size(), hecho_at.size());
    end
    for (int i = 0; i < 12 && i < strobes.size(); i++) begin
      vectors++;
      if (strobes[i].wr !== 1'b1 || strobes[i].rd !== 1'b0 || strobes[i].sel !== exp_sel[i]) begin
        miscompares++;
        $display("FAIL prio_strobe%0d: got wr=%b rd=%b sel=%h, want wr=1 rd=0 sel=%h", i,
                 strobes[i].wr, strobes[i].rd, strobes[i].sel, exp_sel[i]);
      end
    end
    vectors++;
    if (hecho_at.size() == 2 && strobes.size() == 12 && strobes[6].cyc_at != hecho_at[0] + 2) begin
      miscompares++;
      $display("FAIL prio_write_start: got hecho+%0d, want hecho+2", strobes[6].cyc_at - hecho_at[0]);
    end
  endtask

  task automatic test_timeout();
    bit ok; logic [7:0] x;
    clear_log(); bus_mode = 0;
    escribir = 1'b1; @(posedge clk); #1; escribir = 1'b0;
    repeat (TO) @(posedge clk);
    #1;
    vectors++;
    if (ocupado !== 1'b1 || error !== 1'b0) begin
      miscompares++; $display("FAIL timeout_early: got ocup=%b err=%b, want 1 0", ocupado, error);
    end
    @(posedge clk); #1;
    vectors++;
    if (ocupado !== 1'b0 || error !== 1'b1 || seleccion !== 8'h00) begin
      miscompares++;
      $display("FAIL timeout_abort: got ocup=%b err=%b sel=%h, want 0 1 00", ocupado, error, seleccion);
    end
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (error !== 1'b1 || hecho_at.size() != 0 || strobes.size() != 1) begin
      miscompares++;
      $display("FAIL timeout_sticky: got err=%b hecho=%0d strobes=%0d, want 1 0 1", error,
               hecho_at.size(), strobes.size());
    end
    // partial READ: first item completes, then the bus goes silent in DATA_WAIT idx 1
    clear_log();
    x = 8'($urandom);
    rd_data = '{x}; bus_budget = 3; bus_delay = 1; bus_mode = 1;
    leer = 1'b1; @(posedge clk); #1; leer = 1'b0;
    vectors++;
    if (error !== 1'b0 || ocupado !== 1'b1) begin
      miscompares++; $display("FAIL timeout_clear: got err=%b ocup=%b, want 0 1", error, ocupado);
    end
    wait_idle(ok); bus_mode = 0; bus_budget = -1;
    exp_rg[0] = x;
    vectors++;
    if (!ok || error !== 1'b1 || hecho_at.size() != 0 || strobes.size() != 4) begin
      miscompares++;
      $display("FAIL timeout_read: got idle=%b err=%b hecho=%0d strobes=%0d, want 1 1 0 4", ok, error,
               hecho_at.size(), strobes.size());
    end
    vectors++;
    if ({RG1, RG2, RG3} !== {exp_rg[0], exp_rg[1], exp_rg[2]}) begin
      miscompares++;
      $display("FAIL timeout_rg: got %h %h %h, want %h %h %h", RG1, RG2, RG3, exp_rg[0], exp_rg[1], exp_rg[2]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; logic [7:0] d0;
    clear_log();
    d0 = 8'($urandom_range(255, 1));
    rd_data = '{d0, 8'h77, 8'h88}; bus_delay = 3; bus_mode = 1;
    leer = 1'b1; @(posedge clk); #1; leer = 1'b0;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (count_rd() >= 2) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    vectors++;
    if (!ok || RG1 !== d0) begin
      miscompares++; $display("FAIL midreset_setup: got reached=%b RG1=%h, want 1 %h", ok, RG1, d0);
    end
    reset = 1'b1; bus_mode = 0;
    @(posedge clk); #1; reset = 1'b0;
    exp_rg = '{8'h00, 8'h00, 8'h00};
    vectors++;
    if (seleccion !== 8'h00 || RG1 !== 8'h00 || ocupado !== 1'b0 || hecho !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_state: got sel=%h RG1=%h ocup=%b hecho=%b, want 00 00 0 0",
               seleccion, RG1, ocupado, hecho);
    end
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if (hecho_at.size() != 0 || ocupado !== 1'b0 || {RG2, RG3, error} !== 17'd0) begin
      miscompares++;
      $display("FAIL midreset_after: got hecho=%0d ocup=%b RG2=%h RG3=%h err=%b, want 0 0 00 00 0",
               hecho_at.size(), ocupado, RG2, RG3, error);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_init_immediate();
    test_read_basic();
    test_read_random();
    test_wrong_kind();
    test_back_to_back();
    test_priority();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
